data_mem_responder: RTL and testbench

Word-organised data memory that services the load/store requests issued by the multicycle RV32I datapath. It holds an internal word-wide synchronous-read array. Loads get byte/halfword lane extraction with sign or zero extension. Stores use lane insertion, with read-modify-write for sub-word stores. A valid/ready request channel and a single-cycle response pulse let the control FSM stall until each access completes.

---
 rtl/data_mem_responder.sv | 194 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory behind a valid/ready load/store channel.
//
// Accepts one request in IDLE, validates alignment, range and funct3, then performs a
// load (byte/half lane extraction with sign/zero extension), a full-word store, or a
// read-modify-write sub-word store. Completion is a one-cycle rsp_valid pulse.
//
// Ports:
//   clk        - clock, all state on rising edge
//   reset      - synchronous, active-low
//   req_valid  - request present
//   req_ready  - high only in IDLE
//   req_we     - 1 store, 0 load
//   req_funct3 - RV32I load/store funct3
//   req_addr   - byte address
//   req_wdata  - store data (sub-word stores use the low bits)
//   rsp_valid  - one-cycle completion pulse
//   rsp_rdata  - extended load data; 0 for stores and errors; held between responses
//   rsp_err    - qualifies rsp_valid: misaligned, out-of-range or illegal funct3
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned ADDR_BITS = $clog2(DEPTH_WORDS);
  // Only the word index and byte offset are needed after accept.
  localparam int unsigned LAT_BITS  = ADDR_BITS + 2;

  typedef enum logic [2:0] {StIdle, StRd, StWr, StErr, StResp} state_e;

  state_e state_q, state_d;

  logic                we_q;
  logic [2:0]          funct3_q;
  logic [LAT_BITS-1:0] addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rd_word_q;

  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [31:0]         rsp_rdata_q;

  logic [31:0]         mem [DEPTH_WORDS];

  logic                accept;
  logic                req_ok;
  logic                funct3_ok;
  logic                align_ok;
  logic                range_ok;
  logic [ADDR_BITS-1:0] word_idx;
  logic [31:0]         mem_rdata;
  logic [31:0]         load_data;
  logic [31:0]         store_word;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign word_idx  = addr_q[ADDR_BITS+1:2];
  assign mem_rdata = mem[word_idx];

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // Request checks on the live inputs, used only in the accept cycle.
  always_comb begin
    funct3_ok = 1'b0;
    if (req_we) begin
      funct3_ok = (req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      funct3_ok = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    align_ok = 1'b1;
    case (req_funct3[1:0])
      2'b01:   align_ok = ~req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  generate
    if (DEPTH_WORDS == (32'd1 << ADDR_BITS)) begin : g_range_pow2
      assign range_ok = ~|req_addr[31:ADDR_BITS+2];
    end else begin : g_range_npow2
      assign range_ok = ~|req_addr[31:ADDR_BITS+2] &&
                        (32'(req_addr[ADDR_BITS+1:2]) < DEPTH_WORDS);
    end
  endgenerate

  assign req_ok = funct3_ok && align_ok && range_ok;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!req_ok) begin
            state_d = StErr;
          end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StErr:   state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Little-endian lane extraction of the word being read in RD.
  always_comb begin
    lane_b    = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (funct3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {24'h000000, lane_b};
      3'b101:  load_data = {16'h0000, lane_h};
      default: load_data = mem_rdata;
    endcase
  end

  // Merge sub-word store data into the word captured in RD.
  always_comb begin
    store_word = rd_word_q;
    case (funct3_q[1:0])
      2'b00: store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) begin
          store_word[31:16] = wdata_q[15:0];
        end else begin
          store_word[15:0] = wdata_q[15:0];
        end
      end
      default: store_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[LAT_BITS-1:0];
        wdata_q  <= req_wdata;
      end
      rsp_valid_q <= (state_d == StResp);
      // ERR always proceeds to RESP, so this marks exactly the error response cycle.
      rsp_err_q   <= (state_q == StErr);
      if ((state_q == StRd) && !we_q) begin
        rsp_rdata_q <= load_data;
      end else if ((state_q == StWr) || (state_q == StErr)) begin
        rsp_rdata_q <= 32'h0;
      end
    end
  end

  // Array is neither reset nor initialised; reset in the WR cycle cancels the commit.
  always_ff @(posedge clk) begin
    if (state_q == StRd) begin
      rd_word_q <= mem_rdata;
    end
    if (reset && (state_q == StWr)) begin
      mem[word_idx] <= store_word;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  bit [31:0] ref_mem [DEPTH];

  data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: access size from funct3, byte-granular memory arithmetic.
  function automatic void model_req(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                    input bit [31:0] wd, output bit err, output int lat,
                                    output bit [31:0] rd);
    int unsigned size;
    int unsigned off;
    int unsigned idx;
    bit          legal;
    bit [31:0]   v;
    bit [31:0]   mask;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = a % 4;
    idx   = a / 4;
    err   = !legal || (a % size != 0) || (idx >= DEPTH);
    rd    = 32'h0;
    lat   = 2;
    if (err) return;
    if (!we) begin
      v = ref_mem[idx] >> (8 * off);
      if (size == 1) begin
        v = v % 32'd256;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2) begin
        v = v % 32'd65536;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      rd = v;
    end else begin
      if (size == 4) mask = 32'hFFFF_FFFF;
      else mask = ((32'd1 << (8 * size)) - 32'd1) << (8 * off);
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << (8 * off)) & mask);
      if (size != 4) lat = 3;
    end
  endfunction

  // Call at posedge+1. Issues one request and waits (bounded) for its response.
  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic err, output logic [31:0] rd);
    int w;
    w = 0;
    while (!req_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    // Junk on the other inputs must not disturb the latched request.
    req_we     = ~we;
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = -1;
    err = 1'bx;
    rd  = 'x;
    for (int c = 1; c <= 6 && lat < 0; c++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        lat = c;
        err = rsp_err;
        rd  = rsp_rdata;
      end
    end
    @(posedge clk); #1;
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    bit        e_err;
    int        e_lat;
    bit [31:0] e_rd;
    int        lat;
    logic      err;
    model_req(we, f3, a, wd, e_err, e_lat, e_rd);
    txn(tag, we, f3, a, wd, lat, err, rd);
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_rdata"}, rd, e_rd);
  endtask

  // Reset is held low for one edge, abort_cyc cycles after the accept edge.
  task automatic abort_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int abort_cyc);
    int seen;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 1; i < abort_cyc; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rdata_rst"}, rsp_rdata, 32'h0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk({tag, "_no_rsp"}, 32'(seen), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic b2b();
    logic [31:0] addrs [4];
    bit [31:0]   exp_rd [4];
    int          acc_cyc [4];
    logic        rdy_log [24];
    int          nacc;
    int          got;
    bit          e_err;
    int          e_lat;
    bit          accepted;
    addrs[0] = 32'h20; addrs[1] = 32'h10; addrs[2] = 32'h44; addrs[3] = 32'h80;
    for (int i = 0; i < 4; i++) model_req(1'b0, 3'd2, addrs[i], 32'h0, e_err, e_lat, exp_rd[i]);
    nacc = 0;
    got  = 0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = addrs[0];
    for (int cyc = 0; cyc < 24 && got < 4; cyc++) begin
      @(negedge clk);
      accepted     = 1'b0;
      rdy_log[cyc] = req_ready;
      if (rsp_valid) begin
        chk($sformatf("b2b_rdata%0d", got), rsp_rdata, exp_rd[got]);
        got++;
      end
      if (req_ready && req_valid && nacc < 4) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      if (accepted) begin
        if (nacc < 4) req_addr = addrs[nacc];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd4);
    chk("b2b_rsps", 32'(got), 32'd4);
    if (nacc == 4) begin
      chk("b2b_first", 32'(acc_cyc[0]), 32'd0);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b2b_gap%0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd3);
        chk($sformatf("b2b_lo1_%0d", i), 32'(rdy_log[acc_cyc[i] + 1]), 32'd0);
        chk($sformatf("b2b_lo2_%0d", i), 32'(rdy_log[acc_cyc[i] + 2]), 32'd0);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  ld_f3 [5];
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 64; i++) run("init", 1'b1, 3'd2, 32'(i * 4), $urandom, rd);

    run("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
    run("lw10", 1'b0, 3'd2, 32'h10, 32'h0, rd);
    chk("lw10_lit", rd, 32'hDEADBEEF);
    run("sb13", 1'b1, 3'd0, 32'h13, 32'h00000055, rd);
    run("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, rd);
    chk("lw10b_lit", rd, 32'h55ADBEEF);

    run("sw20", 1'b1, 3'd2, 32'h20, 32'h80FF7F01, rd);
    run("lb20", 1'b0, 3'd0, 32'h20, 32'h0, rd);
    chk("lb20_lit", rd, 32'h00000001);
    run("lb23", 1'b0, 3'd0, 32'h23, 32'h0, rd);
    chk("lb23_lit", rd, 32'hFFFFFF80);
    run("lbu23", 1'b0, 3'd4, 32'h23, 32'h0, rd);
    chk("lbu23_lit", rd, 32'h00000080);
    run("lh22", 1'b0, 3'd1, 32'h22, 32'h0, rd);
    chk("lh22_lit", rd, 32'hFFFF80FF);
    run("lhu22", 1'b0, 3'd5, 32'h22, 32'h0, rd);
    chk("lhu22_lit", rd, 32'h000080FF);

    run("err_lw21", 1'b0, 3'd2, 32'h21, 32'h0, rd);
    run("err_sh03", 1'b1, 3'd1, 32'h03, 32'hFFFF_FFFF, rd);
    run("err_range", 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, rd);
    run("err_f3", 1'b0, 3'd3, 32'h20, 32'h0, rd);
    run("err_f3st", 1'b1, 3'd4, 32'h20, 32'h0, rd);
    run("reread20", 1'b0, 3'd2, 32'h20, 32'h0, rd);
    chk("reread20_lit", rd, 32'h80FF7F01);
    run("reread00", 1'b0, 3'd2, 32'h00, 32'h0, rd);

    abort_txn("abort_rd", 1'b1, 3'd1, 32'h40, 32'h1234, 1);
    run("lw40", 1'b0, 3'd2, 32'h40, 32'h0, rd);
    abort_txn("abort_wr", 1'b1, 3'd0, 32'h45, 32'hA5, 2);
    run("lw44", 1'b0, 3'd2, 32'h44, 32'h0, rd);

    b2b();

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_f3[$urandom_range(0, 4)];
      r = int'($urandom_range(0, 9));
      if (r == 0) a = 32'(DEPTH * 4) + $urandom_range(0, 255);
      else if (r == 1) a = $urandom | 32'h8000_0000;
      else a = $urandom_range(0, 255);
      run($sformatf("rnd%0d", i), we, f3, a, $urandom, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
